// File: rtl/codificador_8x3_seq.sv
// Serializes a multi-hot 8-bit request word into 3-bit decoder select codes, d[7] first.
// Latency 1 cycle from accept to first code; upstream is stalled while a word is being emitted.
module codificador_8x3_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] a,
  output logic       out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [2:0] code;
  logic [7:0] code_bit;
  logic       single;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);

  // Code k selects d[7-k]; scanning k downward leaves the lowest set code.
  always_comb begin
    code = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (pending_q[7-k]) code = 3'(k);
    end
  end

  assign code_bit  = 8'h80 >> code;
  assign single    = (pending_q != 8'h00) && ((pending_q & (pending_q - 8'h01)) == 8'h00);
  assign pending_d = pending_q & ~code_bit;

  assign a        = out_valid ? code : 3'd0;
  assign out_last = out_valid & single;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero word is accepted and silently dropped.
          if (in_valid && d != 8'h00) begin
            pending_q <= d;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending_q <= pending_d;
            if (single) state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_8x3_seq.sv
// Scoreboard bench: stimulus queues expected codes/words, a negedge monitor pops and compares.
module tb_codificador_8x3_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] a;
  logic       out_last;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int cyc = 0;
  bit toggle_mode = 0;

  logic [3:0] exp_q[$];
  logic [7:0] word_q[$];
  logic [7:0] acc = 8'h00;

  codificador_8x3_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // out_ready pattern: always high, or 1,0,0,1,0,0,...
  always @(posedge clk) begin
    #1;
    cyc++;
    out_ready = toggle_mode ? (cyc % 3 == 0) : 1'b1;
  end

  logic       prev_stall = 1'b0;
  logic [2:0] prev_a;
  logic       prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_code", {28'd0, a, out_last}, {28'd0, prev_a, prev_last});
      end
      if (!out_valid) chk("idle_outputs_zero", {28'd0, a, out_last}, 32'd0);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_code", {28'd0, a, out_last}, 32'hFFFF);
        end else begin
          chk("code_last", {28'd0, a, out_last}, {28'd0, exp_q.pop_front()});
        end
        acc = acc | (8'h80 >> a);
        if (out_last) begin
          if (word_q.size() == 0) chk("loopback_unexpected", 32'(acc), 32'hFFFF);
          else chk("loopback_word", 32'(acc), 32'(word_q.pop_front()));
          acc = 8'h00;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_a     = a;
      prev_last  = out_last;
    end
  end

  // Expected codes for a word, scanned directly from its bit positions.
  task automatic push_expect(input logic [7:0] v);
    int remaining;
    remaining = $countones(v);
    for (int k = 0; k < 8; k++) begin
      if (v[7-k]) begin
        remaining--;
        exp_q.push_back({3'(k), remaining == 0});
      end
    end
    if (v != 8'h00) word_q.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    d = v;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    push_expect(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    d = 8'h00;
    chk("latency_valid", 32'(out_valid), 32'(v != 8'h00));
    chk("latency_in_ready", 32'(in_ready), 32'(v == 8'h00));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b1; in_valid = 1'b0; d = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a_last", {28'd0, a, out_last}, 32'd0);

    // Single top bit
    send(8'b1000_0000);
    chk("t1_a", 32'(a), 32'd0);
    chk("t1_last", 32'(out_last), 32'd1);
    @(posedge clk); #1;
    chk("t1_back_idle", {30'd0, in_ready, out_valid}, 32'b10);

    // Four codes back to back, p+1 cycles
    send(8'b1010_0101);
    chk("t2_first_a", 32'(a), 32'd0);
    wait_idle(n);
    chk("t2_cycles", 32'(n), 32'd4);

    // Full word under back-pressure
    toggle_mode = 1;
    send(8'hFF);
    wait_idle(n);
    toggle_mode = 0;

    // Zero word dropped, then next word immediately
    send(8'h00);
    send(8'h01);
    chk("t4_a", 32'(a), 32'd7);
    chk("t4_last", 32'(out_last), 32'd1);
    wait_idle(n);

    // Reset mid-word after code 1 taken
    base = hs_cnt;
    send(8'hF0);
    n = 0;
    while (hs_cnt < base + 2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("t5_hs_timeout", 32'd0, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    word_q.delete();
    acc = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_a", 32'(a), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    send(8'h08);
    chk("t5_new_a", 32'(a), 32'd4);
    wait_idle(n);

    // Loopback over every word
    for (int v = 0; v < 256; v++) begin
      toggle_mode = (v % 4 == 3);
      send(8'(v));
      wait_idle(n);
    end
    toggle_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_codes_drained", 32'(exp_q.size()), 32'd0);
    chk("sb_words_drained", 32'(word_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
